// File: rtl/ahb2_copy_master_pkg.sv
// ahb2_copy_master_pkg: AHB-Lite encodings shared by the copy master and its bus peers
package ahb2_copy_master_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
endpackage

// File: rtl/ahb2_copy_master.sv
// ahb2_copy_master: AHB-Lite master copying words one SINGLE read + one SINGLE write at a time
module ahb2_copy_master
  import ahb2_copy_master_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          haddr,
  output logic [1:0]           htrans,
  output logic                 hwrite,
  output logic [2:0]           hsize,
  output logic [2:0]           hburst,
  output logic [31:0]          hwdata,
  input  logic [31:0]          hrdata,
  input  logic                 hready,
  input  logic                 hresp
);
  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_D, S_WR_A, S_WR_D, S_FIN} state_t;
  state_t state, state_nx;
  logic [31:0] src, dst, src_nx, dst_nx, data_reg;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic abort;
  assign hsize  = HSIZE_WORD;
  assign hburst = HBURST_SINGLE;
  always_comb begin
    abort    = hready && hresp == HRESP_ERROR && (state == S_RD_D || state == S_WR_D);
    state_nx = state;
    src_nx   = src;
    dst_nx   = dst;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: if (start) begin
        src_nx   = {src_addr[31:2], 2'b00};
        dst_nx   = {dst_addr[31:2], 2'b00};
        cnt_nx   = word_cnt;
        state_nx = word_cnt == '0 ? S_FIN : S_RD_A;
      end
      S_RD_A: state_nx = hready ? S_RD_D : S_RD_A;
      S_RD_D: state_nx = !hready ? S_RD_D : abort ? S_FIN : S_WR_A;
      S_WR_A: state_nx = hready ? S_WR_D : S_WR_A;
      S_WR_D: if (hready) begin
        if (abort) state_nx = S_FIN;
        else begin
          src_nx   = src + 32'd4;
          dst_nx   = dst + 32'd4;
          cnt_nx   = cnt - 1'b1;
          state_nx = cnt_nx == '0 ? S_FIN : S_RD_A;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end
  // Bus outputs are registered from the next state so they line up with the phase being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      src      <= '0;
      dst      <= '0;
      cnt      <= '0;
      data_reg <= '0;
      htrans   <= HTRANS_IDLE;
      haddr    <= '0;
      hwrite   <= 1'b0;
      hwdata   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      src      <= src_nx;
      dst      <= dst_nx;
      cnt      <= cnt_nx;
      data_reg <= (state == S_RD_D && hready && hresp == HRESP_OKAY) ? hrdata : data_reg;
      htrans   <= (state_nx == S_RD_A || state_nx == S_WR_A) ? HTRANS_NONSEQ : HTRANS_IDLE;
      haddr    <= state_nx == S_RD_A ? src_nx : state_nx == S_WR_A ? dst_nx : haddr;
      hwrite   <= state_nx == S_WR_A;
      hwdata   <= state_nx == S_WR_D ? data_reg : hwdata;
      busy     <= state_nx inside {S_RD_A, S_RD_D, S_WR_A, S_WR_D};
      done     <= state_nx == S_FIN;
      err      <= state_nx == S_FIN && abort;
    end
  end
endmodule

// File: tb/tb_ahb2_copy_master.sv
// tb_ahb2_copy_master: copy master against a word-memory slave model with wait/error injection
module tb_ahb2_copy_master;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] word_cnt = '0;
  logic busy, done, err, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0] htrans;
  logic [2:0] hsize, hburst;
  logic [31:0] hrdata = '0;
  logic hready = 1'b1, hresp = 1'b0;
  always #5 clk = ~clk;
  ahb2_copy_master #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_cnt(word_cnt), .busy(busy), .done(done), .err(err), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp)
  );
  typedef struct {int c0; int lat; bit err; int nacc; logic [31:0] src; logic [31:0] dst; int nw;} exp_t;
  exp_t sb[$];
  logic [31:0] mem [0:65535];
  logic [31:0] ref_mem [0:65535];
  int cyc = 0, n_chk = 0, n_fail = 0, wait_n = 0, err_idx = -1;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Slave: bookkeeping on the clock edge, responses driven just after the falling edge
  logic dp_valid = 1'b0, dp_write = 1'b0, dp_err = 1'b0, loaded = 1'b0;
  logic [15:0] dp_addr = '0;
  int dp_age = 0, rd_idx = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid <= 1'b0;
      dp_err <= 1'b0;
      dp_age <= 0;
    end else if (!loaded) begin
      for (int i = 0; i < 65536; i++) mem[i] <= i;
      loaded <= 1'b1;
    end else begin
      if (hready) begin
        if (dp_valid && dp_write && !dp_err) mem[dp_addr] <= hwdata;
        dp_valid <= htrans == 2'b10;
        dp_write <= hwrite;
        dp_addr <= haddr[17:2];
        dp_age <= 0;
        dp_err <= htrans == 2'b10 && !hwrite && rd_idx == err_idx;
        if (htrans == 2'b10 && !hwrite) rd_idx <= rd_idx + 1;
      end else dp_age <= dp_age + 1;
      if (start) rd_idx <= 0;
    end
  end
  always @(negedge clk) begin
    #1;
    hresp = dp_valid && dp_err;
    hready = !dp_valid || dp_age >= (dp_err ? 1 : wait_n);
    hrdata = (dp_valid && !dp_write && !dp_err) ? mem[dp_addr] : 32'h0;
  end
  // Reference: sequential word copy, aliased onto the slave's 64K-word space
  function automatic exp_t model(input logic [31:0] s, input logic [31:0] d, input int n, input int w, input int ek);
    exp_t e;
    int k;
    logic [31:0] ra, wa;
    e.src = {s[31:2], 2'b00};
    e.dst = {d[31:2], 2'b00};
    k = (ek >= 0 && ek < n) ? ek : n;
    for (int i = 0; i < k; i++) begin
      ra = e.src + 32'(4 * i);
      wa = e.dst + 32'(4 * i);
      ref_mem[wa[17:2]] = ref_mem[ra[17:2]];
    end
    e.err = k < n;
    e.nw = k;
    e.nacc = 2 * k + (e.err ? 1 : 0);
    e.lat = n == 0 ? 1 : e.err ? k * (4 + 2 * w) + 4 : n * (4 + 2 * w) + 1;
    e.c0 = 0;
    return e;
  endfunction
  // Monitor: address-phase ordering/holds and done-time scoreboard pops
  logic [1:0] p_htrans = 2'b00;
  logic [31:0] p_haddr = '0, p_hwdata = '0;
  logic p_hwrite = 1'b0, p_wdp = 1'b0;
  int nacc = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_htrans = 2'b00;
      p_wdp = 1'b0;
      nacc = 0;
      sb.delete();
    end else begin
      if (p_htrans == 2'b10 && !hready) begin
        chk("addr_hold", haddr, p_haddr);
        chk("trans_hold", htrans, p_htrans);
      end
      if (p_htrans == 2'b10 && hready) begin
        chk("no_back_to_back", htrans, 2'b00);
        if (sb.size() > 0) begin
          chk(nacc % 2 ? "wr_haddr" : "rd_haddr", p_haddr, (nacc % 2 ? sb[0].dst : sb[0].src) + 32'(4 * (nacc / 2)));
          chk("hwrite", p_hwrite, nacc % 2);
        end
        nacc++;
      end
      if (p_wdp && !hready) chk("wdata_hold", hwdata, p_hwdata);
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no command pending (cycle %0d)", cyc);
        end else begin
          exp_t e;
          logic [31:0] wa;
          e = sb.pop_front();
          chk("latency", cyc - e.c0, e.lat);
          chk("err", err, e.err);
          chk("addr_phases", nacc, e.nacc);
          chk("busy_at_done", busy, 1'b0);
          chk("hsize", hsize, 3'b010);
          chk("hburst", hburst, 3'b000);
          for (int i = 0; i < e.nw; i++) begin
            wa = e.dst + 32'(4 * i);
            chk("mem_word", mem[wa[17:2]], ref_mem[wa[17:2]]);
          end
        end
        nacc = 0;
      end
      p_htrans = htrans;
      p_haddr = haddr;
      p_hwrite = hwrite;
      p_hwdata = hwdata;
      p_wdp = dp_valid && dp_write;
    end
  end
  task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n, input int w, input int ek, input int mn, input bit push);
    exp_t e;
    wait_n = w;
    err_idx = ek;
    src_addr = s;
    dst_addr = d;
    word_cnt = 16'(n);
    start = 1'b1;
    e = model(s, d, mn, w, ek);
    e.c0 = cyc;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, n != 0);
  endtask
  task automatic wait_done();
    int k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got done=0 expected 1 within 3000 cycles");
    end
    @(negedge clk);
  endtask
  initial begin
    int bad, n, ek;
    for (int i = 0; i < 65536; i++) ref_mem[i] = i;
    repeat (3) @(negedge clk);
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwrite", hwrite, 1'b0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_hsize", hsize, 3'b010);
    chk("rst_hburst", hburst, 3'b000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(32'h100, 32'h200, 4, 0, -1, 4, 1);
    wait_done();
    for (int i = 0; i < 4; i++) chk("basic_word", mem[16'h80 + i], 32'h40 + i);
    issue(32'h300, 32'h400, 0, 0, -1, 0, 1);
    wait_done();
    issue(32'h500, 32'h600, 2, 2, -1, 2, 1);
    wait_done();
    issue(32'h700, 32'h800, 4, 0, 1, 4, 1);
    wait_done();
    chk("abort_word0", mem[16'h200], 32'h1C0);
    chk("abort_word1_untouched", mem[16'h201], 32'h201);
    issue(32'h900, 32'hA00, 4, 1, -1, 4, 1);
    repeat (3) @(negedge clk);
    src_addr = 32'h1000;
    dst_addr = 32'h2000;
    word_cnt = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("ignored_start_dst", mem[16'h800], 32'h800);
    issue(32'hFFFF_FFFE, 32'h3000, 2, 0, -1, 2, 1);
    wait_done();
    issue(32'h4000, 32'h5000, 4, 0, -1, 2, 0);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_htrans", htrans, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_haddr", haddr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'h6000, 32'h7000, 3, 0, -1, 3, 1);
    wait_done();
    repeat (12) begin
      n = $urandom_range(1, 6);
      ek = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, n - 1)) : -1;
      issue($urandom, $urandom, n, $urandom_range(0, 2), ek, n, 1);
      wait_done();
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_sweep_mismatches", bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
